// File: rtl/dff_edge_capture.sv
// dff_edge_capture: clk-domain replacement for a discrete edge-triggered D flop.
// The former flop clock `cp` is sampled as a level on `clk`. A detected edge of
// `cp` loads `d` into `q`, and `qn` is always the complement of `q`.
// Optional macro DFF_EDGE_CAPTURE_CP_SYNC_EN adds a 2-flop synchronizer on `cp`.
// With the macro, `cp` may be asynchronous to `clk` and capture latency grows
// from 1 to 3 cycles.
module dff_edge_capture #(
  parameter int unsigned      WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter bit               CP_FALLING  = 1'b0
) (
  input  logic             clk,
  input  logic             r,
  input  logic             cp,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn
);

  // Strobe seen by the edge detector. It is either raw `cp` or its synchronized copy.
  logic cp_s;

`ifdef DFF_EDGE_CAPTURE_CP_SYNC_EN
  logic cp_meta_q;
  logic cp_sync_q;

  // Two-flop synchronizer bringing a possibly asynchronous cp into the clk domain.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would collapse the two stages into one.
    if (r) begin
      cp_meta_q <= 1'b0;
      cp_sync_q <= 1'b0;
    end else begin
      cp_meta_q <= cp;
      cp_sync_q <= cp_meta_q;
    end
  end

  assign cp_s = cp_sync_q;
`else
  assign cp_s = cp;
`endif

  logic             cp_prev_q;
  logic             capture;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Edge detect. The active direction is chosen by CP_FALLING.
  always_comb begin
    if (CP_FALLING) begin
      capture = !cp_s && cp_prev_q;
    end else begin
      capture = cp_s && !cp_prev_q;
    end
  end

  // Next data value: load d on a detected edge, otherwise hold.
  always_comb begin
    // NOTE: default assignment first so every path drives q_d and no latch is inferred.
    q_d = q_q;
    if (capture) begin
      q_d = d;
    end
  end

  // State register. A synchronous reset wins over capture and clears the edge history.
  always_ff @(posedge clk) begin
    if (r) begin
      q_q       <= RESET_VALUE;
      cp_prev_q <= 1'b0;
    end else begin
      q_q       <= q_d;
      cp_prev_q <= cp_s;
    end
  end

  assign q  = q_q;
  assign qn = ~q_q;

endmodule

// File: tb/tb_dff_edge_capture.sv
// tb_dff_edge_capture: drives two configurations of dff_edge_capture.
// Instance a is WIDTH=1 with a rising-edge strobe. Instance b is WIDTH=4 with a
// falling-edge strobe and a non-zero reset value. Both run directed scenarios,
// then randomized stimulus. Each instance is compared after every clk edge
// against a reference model built on a history of sampled strobe values.
module tb_dff_edge_capture;

`ifdef DFF_EDGE_CAPTURE_CP_SYNC_EN
  localparam int LAT_D = 2;
`else
  localparam int LAT_D = 0;
`endif

  logic       clk = 1'b0;
  logic       r_a, cp_a, d_a, q_a, qn_a;
  logic       r_b, cp_b;
  logic [3:0] d_b, q_b, qn_b;

  int total = 0;
  int bad   = 0;

  logic [3:0] ma_q   = '0;
  logic [3:0] mb_q   = '0;
  logic [7:0] hist_a = '0;
  logic [7:0] hist_b = '0;

  always #5 clk = ~clk;

  dff_edge_capture #(.WIDTH(1), .RESET_VALUE(1'b0), .CP_FALLING(1'b0)) dut_a (
    .clk(clk), .r(r_a), .cp(cp_a), .d(d_a), .q(q_a), .qn(qn_a)
  );

  dff_edge_capture #(.WIDTH(4), .RESET_VALUE(4'h6), .CP_FALLING(1'b1)) dut_b (
    .clk(clk), .r(r_b), .cp(cp_b), .d(d_b), .q(q_b), .qn(qn_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model step. hist holds sampled strobe values, newest in bit 0.
  // The detector looks LAT_D samples back. Reset forces LAT_D+1 zero samples.
  function automatic void model_step(input logic rst, input logic cpv,
                                     input logic [3:0] dv, input logic [3:0] rv,
                                     input bit falling,
                                     inout logic [3:0] mq, inout logic [7:0] hist);
    logic cur;
    logic prev;
    if (rst) begin
      mq   = rv;
      hist = hist << (LAT_D + 1);
    end else begin
      hist = {hist[6:0], cpv};
      cur  = hist[LAT_D];
      prev = hist[LAT_D+1];
      if (falling ? (!cur && prev) : (cur && !prev)) mq = dv;
    end
  endfunction

  task automatic tick();
    logic       ea_qn;
    logic [3:0] eb_qn;
    @(posedge clk);
    model_step(r_a, cp_a, {3'b000, d_a}, 4'h0, 1'b0, ma_q, hist_a);
    model_step(r_b, cp_b, d_b, 4'h6, 1'b1, mb_q, hist_b);
    #1;
    ea_qn = ~ma_q[0];
    eb_qn = ~mb_q;
    check("a_q", q_a, ma_q);
    check("a_qn", qn_a, ea_qn);
    check("b_q", q_b, mb_q);
    check("b_qn", qn_b, eb_qn);
  endtask

  task automatic drive_a(input logic rv, input logic cpv, input logic dv);
    r_a = rv; cp_a = cpv; d_a = dv;
  endtask

  initial begin
    r_a = 1'b1; cp_a = 1'b1; d_a = 1'b1;
    r_b = 1'b1; cp_b = 1'b0; d_b = 4'h0;

    // Reset held for two edges with cp=1, d=1.
    tick();
    tick();
`ifndef DFF_EDGE_CAPTURE_CP_SYNC_EN
    check("rst_q", q_a, 1'b0);
    check("rst_qn", qn_a, 1'b1);
    check("rst_b_q", q_b, 4'h6);
`endif
    // Release with cp still high: the first non-reset edge captures.
    drive_a(1'b0, 1'b1, 1'b1);
    tick();
`ifndef DFF_EDGE_CAPTURE_CP_SYNC_EN
    check("rel_cap", q_a, 1'b1);
`endif
    // Basic capture, then cp held high while d toggles.
    drive_a(1'b0, 1'b0, 1'b1); tick();
    drive_a(1'b0, 1'b1, 1'b1); tick();
    for (int i = 0; i < 5; i++) begin
      drive_a(1'b0, 1'b1, 1'(i[0])); tick();
    end
`ifndef DFF_EDGE_CAPTURE_CP_SYNC_EN
    check("hold_hi", q_a, 1'b1);
`endif
    // Capture of zero, then a falling cp causes no change.
    drive_a(1'b0, 1'b0, 1'b0); tick();
    drive_a(1'b0, 1'b1, 1'b0); tick();
`ifndef DFF_EDGE_CAPTURE_CP_SYNC_EN
    check("cap0_q", q_a, 1'b0);
    check("cap0_qn", qn_a, 1'b1);
`endif
    drive_a(1'b0, 1'b0, 1'b1); tick();
    // No strobe for 7 cycles while d toggles.
    for (int i = 0; i < 7; i++) begin
      drive_a(1'b0, 1'b0, 1'(i[0])); tick();
    end
    // Load a 1, then drop cp.
    drive_a(1'b0, 1'b1, 1'b1); tick();
    drive_a(1'b0, 1'b0, 1'b1); tick();
    for (int i = 0; i < 3; i++) tick();
    // Raising r between edges must not change q before the next edge.
    drive_a(1'b1, 1'b1, 1'b1);
    #1;
    check("no_async", q_a, ma_q);
    tick();
`ifndef DFF_EDGE_CAPTURE_CP_SYNC_EN
    check("rst_prio", q_a, 1'b0);
`endif
    drive_a(1'b0, 1'b1, 1'b1); tick();
`ifndef DFF_EDGE_CAPTURE_CP_SYNC_EN
    check("post_rst", q_a, 1'b1);
`endif

    // Falling-edge instance, WIDTH=4.
    r_b = 1'b0; cp_b = 1'b1; d_b = 4'h3; tick();
    cp_b = 1'b0; d_b = 4'hA; tick();
    for (int i = 0; i < LAT_D; i++) tick();
`ifndef DFF_EDGE_CAPTURE_CP_SYNC_EN
    check("fall_q", q_b, 4'hA);
    check("fall_qn", qn_b, 4'h5);
`endif
    cp_b = 1'b1; d_b = 4'hC; tick();
    for (int i = 0; i < LAT_D; i++) tick();
`ifndef DFF_EDGE_CAPTURE_CP_SYNC_EN
    check("rise_hold", q_b, 4'hA);
`endif

    // Randomized traffic on both instances.
    for (int i = 0; i < 400; i++) begin
      r_a  = ($urandom_range(0, 15) == 0);
      cp_a = 1'($urandom_range(0, 1));
      d_a  = 1'($urandom_range(0, 1));
      r_b  = ($urandom_range(0, 15) == 0);
      cp_b = 1'($urandom_range(0, 1));
      d_b  = 4'($urandom_range(0, 15));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
